// File: rtl/count_capture_pkg.sv
// Shared types and defaults for the count_capture snapshot block.
package count_capture_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef struct packed {
    logic                 wrap;
    logic [WIDTH_DEF-1:0] data;
  } cap_entry_t;

  function automatic int entry_bits(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/count_capture_fifo.sv
// Snapshot storage: circular buffer with level-derived full/empty.
module count_capture_fifo #(
  parameter  int W     = 9,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic [LW-1:0] o_level,
  output logic          o_full,
  output logic          o_empty
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [LW-1:0] r_level;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (i_pop)  r_rptr <= r_rptr + 1'b1;
      r_level <= r_level + LW'(i_push) - LW'(i_pop);
    end
  end

  assign o_level = r_level;
  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  // Head reads as zero when empty so reset leaves clean outputs.
  assign o_data  = o_empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/count_capture.sv
// Counter snapshot queue with sticky overflow; optional wrap tagging
// is enabled by defining COUNT_CAPTURE_WRAP_EN.
module count_capture
  import count_capture_pkg::*;
#(
  parameter  int WIDTH = WIDTH_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count,
  input  logic             cap_req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wrap,
  output logic [LW-1:0]    level,
  output logic             overflow
);

  typedef struct packed {
    logic             wrap;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t w_in;
  entry_t w_head;
  logic   w_push;
  logic   w_pop;
  logic   w_drop;
  logic   w_full;
  logic   w_empty;
  logic   r_ovf;

  assign out_valid = !w_empty;
  assign w_pop     = out_valid & out_ready;
  // A full queue still accepts when the head leaves this cycle.
  assign w_push    = cap_req & (!w_full | w_pop);
  assign w_drop    = cap_req & !w_push;
  assign w_in.data = count;

`ifdef COUNT_CAPTURE_WRAP_EN
  logic [WIDTH-1:0] r_prev;
  logic             r_wpend;
  logic             w_wrap_now;

  assign w_wrap_now = (count == '0) && (r_prev == '1);
  assign w_in.wrap  = r_wpend | w_wrap_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev  <= '0;
      r_wpend <= 1'b0;
    end else begin
      r_prev <= count;
      if (w_push)          r_wpend <= 1'b0;
      else if (w_wrap_now) r_wpend <= 1'b1;
    end
  end
`else
  assign w_in.wrap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst)         r_ovf <= 1'b0;
    else if (w_drop) r_ovf <= 1'b1;
  end

  count_capture_fifo #(
    .W     (entry_bits(WIDTH)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_data  (w_head),
    .o_level (level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_data = w_head.data;
  assign out_wrap = w_head.wrap;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_count_capture.sv
// Directed bench for count_capture (WIDTH=8, DEPTH=4).
module tb_count_capture;

`ifdef COUNT_CAPTURE_WRAP_EN
  localparam logic WRAP_EN = 1'b1;
`else
  localparam logic WRAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] count;
  logic       cap_req;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_wrap;
  logic [2:0] level;
  logic       overflow;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_capture #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .count     (count),
    .cap_req   (cap_req),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .level     (level),
    .overflow  (overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [7:0] v);
    count   = v;
    cap_req = 1'b1;
    tick();
    cap_req = 1'b0;
  endtask

  task automatic idle(input logic [7:0] v);
    count = v;
    tick();
  endtask

  task automatic drain(input string tag, input logic [7:0] d,
                       input logic w);
    out_ready = 1'b1;
    chk({tag, "_vld"}, 32'(out_valid), 32'd1);
    chk({tag, "_dat"}, 32'(out_data), 32'(d));
    chk({tag, "_wrp"}, 32'(out_wrap), 32'(w));
    tick();
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    count     = '0;
    cap_req   = 1'b0;
    out_ready = 1'b0;
    tick();
    do_reset();
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_lvl", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dat", 32'(out_data), 32'd0);
    chk("rst_wrp", 32'(out_wrap), 32'd0);

    // basic order and one-cycle latency
    cap(8'd5);
    chk("lat_vld", 32'(out_valid), 32'd1);
    chk("lat_lvl", 32'(level), 32'd1);
    cap(8'd6);
    cap(8'd7);
    chk("b_lvl3", 32'(level), 32'd3);
    out_ready = 1'b1;
    chk("b_d0", 32'(out_data), 32'd5);
    tick();
    chk("b_d1", 32'(out_data), 32'd6);
    tick();
    chk("b_d2", 32'(out_data), 32'd7);
    tick();
    chk("b_empty", 32'(out_valid), 32'd0);
    chk("b_lvl0", 32'(level), 32'd0);
    tick();
    chk("b_rdy_noeff", 32'(level), 32'd0);
    out_ready = 1'b0;

    // overflow while full
    for (int i = 0; i < 4; i++) cap(8'(10 + i));
    chk("o_lvl4", 32'(level), 32'd4);
    chk("o_ovf0", 32'(overflow), 32'd0);
    cap(8'd14);
    cap(8'd15);
    chk("o_lvl", 32'(level), 32'd4);
    chk("o_ovf1", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) drain("o_dr", 8'(10 + i), 1'b0);
    chk("o_end", 32'(out_valid), 32'd0);
    chk("o_sticky", 32'(overflow), 32'd1);
    do_reset();
    chk("o_rst", 32'(overflow), 32'd0);

    // push and pop together while full
    for (int i = 0; i < 4; i++) cap(8'(20 + i));
    count     = 8'd24;
    cap_req   = 1'b1;
    out_ready = 1'b1;
    tick();
    cap_req   = 1'b0;
    out_ready = 1'b0;
    chk("f_lvl", 32'(level), 32'd4);
    chk("f_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) drain("f_dr", 8'(21 + i), 1'b0);
    chk("f_end", 32'(out_valid), 32'd0);

    // wrap seen between captures
    idle(8'd254);
    idle(8'd255);
    idle(8'd0);
    cap(8'd1);
    cap(8'd2);
    drain("w1", 8'd1, WRAP_EN);
    drain("w2", 8'd2, 1'b0);
    // wrap on the capture cycle itself
    idle(8'd254);
    idle(8'd255);
    cap(8'd0);
    cap(8'd1);
    drain("w3", 8'd0, WRAP_EN);
    drain("w4", 8'd1, 1'b0);
    // dropped capture keeps the pending wrap
    for (int i = 0; i < 4; i++) cap(8'(250 + i));
    idle(8'd255);
    cap(8'd0);
    for (int i = 0; i < 4; i++) drain("w_dr", 8'(250 + i), 1'b0);
    cap(8'd9);
    drain("w5", 8'd9, WRAP_EN);
    do_reset();

    // reset mid-operation
    cap(8'd30);
    cap(8'd31);
    cap(8'd32);
    chk("r_lvl3", 32'(level), 32'd3);
    rst     = 1'b1;
    count   = 8'd99;
    cap_req = 1'b1;
    tick();
    rst     = 1'b0;
    cap_req = 1'b0;
    chk("r_vld", 32'(out_valid), 32'd0);
    chk("r_lvl", 32'(level), 32'd0);
    chk("r_ovf", 32'(overflow), 32'd0);
    cap(8'd40);
    chk("r_lvl1", 32'(level), 32'd1);
    drain("r_new", 8'd40, 1'b0);
    chk("r_end", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/count_capture.md
COUNT_CAPTURE -- requirements
Module: count_capture

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the bit width of the monitored counter value.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of snapshot entries (power of two, >= 2).
REQ-003 Port clk  input  1  sole clock; all logic on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port count  input  WIDTH  live value from the upstream counter.
REQ-006 Port cap_req  input  1  capture strobe; one snapshot request per cycle high.
REQ-007 Port out_valid  output  1  a snapshot is available at the head.
REQ-008 Port out_ready  input  1  consumer accepts the head snapshot.
REQ-009 Port out_data  output  WIDTH  captured count value of the head entry.
REQ-010 Port out_wrap  output  1  the head entry saw a counter wrap since the previous capture.
REQ-011 Port level  output  $clog2(DEPTH)+1  number of stored entries.
REQ-012 Port overflow  output  1  sticky flag; a capture was dropped.

Function
REQ-013 A push SHALL occur on a cycle where cap_req=1 and (level<DEPTH, or level=DEPTH with out_valid=1 and out_ready=1); the entry SHALL be {wrap_pending_or_wrap_now, count} sampled that cycle.
REQ-014 A pop SHALL occur on a cycle where out_valid=1 and out_ready=1; out_ready while out_valid=0 SHALL have no effect.
REQ-015 Push-to-out_valid latency SHALL be exactly 1 cycle; there is no same-cycle bypass.
REQ-016 Simultaneous push and pop SHALL leave level unchanged at any fill level, including full.
REQ-017 A capture request while full and not popping SHALL be dropped and SHALL set overflow, which holds until rst.
REQ-018 out_data and out_wrap SHALL be checked only while out_valid=1; entries SHALL leave in FIFO order.
REQ-019 Read/write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from level (0 means empty, DEPTH means full).
REQ-020 Wrap detection: a wrap SHALL be flagged on a cycle where count=0 and the registered previous count is all ones.
REQ-021 A wrap SHALL set wrap_pending; a successful push SHALL clear wrap_pending; a wrap and a push in the same cycle SHALL give the pushed entry out_wrap=1 and leave wrap_pending=0.
REQ-022 A dropped capture SHALL NOT clear wrap_pending.

Reset
REQ-023 With rst=1, at the next edge: out_valid=0, level=0, overflow=0, out_data=0, out_wrap=0, pointers=0, wrap_pending=0, previous count=0.
REQ-024 Reset mid-operation SHALL discard all stored entries; cap_req is ignored during the reset cycle.

Configuration
REQ-025 Macro COUNT_CAPTURE_WRAP_EN: when defined, REQ-020 to REQ-022 apply.
REQ-026 When COUNT_CAPTURE_WRAP_EN is undefined, wrap logic and the previous-count register SHALL be absent, and out_wrap SHALL be constant 0.

Structure
REQ-027 Package count_capture_pkg SHALL hold the entry struct typedef {wrap, data} parameterised via WIDTH and the default constants WIDTH_DEF=8 and DEPTH_DEF=4.
REQ-028 Storage SHALL be one sub-module, count_capture_fifo (push/pop/level/full/empty); wrap detection and the overflow flag stay in the top.

Verification (WIDTH=8, DEPTH=4, macro defined unless stated)
REQ-029 Reset, then cap_req at count=5, 6, 7 with out_ready=0 -> level=3; then out_ready=1 -> out_data 5, 6, 7 on consecutive cycles, then out_valid=0.
REQ-030 Fill to 4, then 2 more cap_req with out_ready=0 -> level=4, overflow=1 and stays 1; drained data equal the first four captures.
REQ-031 Full, then cap_req=1 and out_ready=1 in the same cycle -> level stays 4, overflow=0, the new entry appears last.
REQ-032 count steps 254, 255, 0, 1, then cap_req at 1 -> out_wrap=1; the next capture -> out_wrap=0. Repeat with cap_req on the cycle count=0 -> that entry has out_wrap=1.
REQ-033 Hold rst=1 for one cycle with 3 entries stored -> out_valid=0, level=0, overflow=0 at the next edge; the next capture returns only new data.
REQ-034 Macro undefined, wrap sequence of REQ-032 -> out_wrap=0 for every entry.
